// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the byte-serial load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Number of memory bytes touched by a request of the given size.
    // The illegal encoding maps to 1; it faults before any access.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            BYTE:    n = 3'd1;
            HALF:    n = 3'd2;
            WORD:    n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Sign/zero extension of assembled little-endian load data.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    // Extend from the top bit of the loaded width; words pass through.
    always_comb begin
        result_o = data_i;
        case (size_i)
            BYTE:    result_o = {{24{~unsigned_i & data_i[7]}},  data_i[7:0]};
            HALF:    result_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
            default: result_o = data_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Byte-serial load/store unit for an 8-bit single-port memory.
//               One request per handshake, little-endian byte sequencing,
//               misaligned/out-of-range requests fault without any access.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic [31:0] mem_address_o,
    output logic        mem_write_enable_o,
    output logic [7:0]  mem_write_data_o,
    input  logic [7:0]  mem_data_i
);

    lsu_state_e  state_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic [31:0] asm_q;
    logic [31:0] rdata_q;
    logic        error_q;
    logic [1:0]  k_q;
    logic [31:0] mem_addr_q;
    logic        mem_we_q;
    logic [7:0]  mem_wdata_q;

    logic [2:0]  w_n;
    logic [32:0] w_end;
    logic        w_fault;
    logic [1:0]  w_last_k;
    logic [1:0]  w_next_k;
    logic [7:0]  w_next_byte;
    logic [31:0] w_asm_next;
    logic [31:0] w_ext;

    // Fault check on the incoming request; the end address is formed in
    // 33 bits so a request near 2^32 cannot wrap back into range.
    always_comb begin
        w_n     = size_to_bytes(req_size_i);
        w_end   = {1'b0, req_addr_i} + 33'(w_n) - 33'd1;
        w_fault = (req_size_i == 2'd3)
               || ((req_size_i == HALF) && req_addr_i[0])
               || ((req_size_i == WORD) && (req_addr_i[1:0] != 2'b00))
               || (w_end >= 33'(MEM_BYTES));
    end

    // Byte sequencing helpers: last index, next store byte, and the load
    // word with the byte currently on the memory port merged into lane k.
    always_comb begin
        w_last_k    = 2'(size_to_bytes(size_q) - 3'd1);
        w_next_k    = k_q + 2'd1;
        w_next_byte = wdata_q[{w_next_k, 3'b000} +: 8];
        w_asm_next  = asm_q;
        w_asm_next[{k_q, 3'b000} +: 8] = mem_data_i;
    end

    load_extend u_load_extend (
        .data_i     (w_asm_next),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .result_o   (w_ext)
    );

    // Control FSM with registered memory-port and response outputs.
    // mem_addr_q doubles as base+k, so the base address needs no copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            size_q      <= 2'd0;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            wdata_q     <= 32'd0;
            asm_q       <= 32'd0;
            rdata_q     <= 32'd0;
            error_q     <= 1'b0;
            k_q         <= 2'd0;
            mem_addr_q  <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        size_q     <= req_size_i;
                        write_q    <= req_write_i;
                        unsigned_q <= req_unsigned_i;
                        wdata_q    <= req_wdata_i;
                        asm_q      <= 32'd0;
                        rdata_q    <= 32'd0;
                        k_q        <= 2'd0;
                        if (w_fault) begin
                            error_q <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            error_q    <= 1'b0;
                            mem_addr_q <= req_addr_i;
                            mem_we_q   <= req_write_i;
                            if (req_write_i) begin
                                mem_wdata_q <= req_wdata_i[7:0];
                            end
                            state_q <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (!write_q) begin
                        asm_q <= w_asm_next;
                    end
                    if (k_q == w_last_k) begin
                        mem_we_q <= 1'b0;
                        k_q      <= 2'd0;
                        if (!write_q) begin
                            rdata_q <= w_ext;
                        end
                        state_q <= RESP;
                    end else begin
                        k_q        <= w_next_k;
                        mem_addr_q <= mem_addr_q + 32'd1;
                        if (write_q) begin
                            mem_wdata_q <= w_next_byte;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        rdata_q <= 32'd0;
                        error_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o        = (state_q == IDLE);
    assign resp_valid_o       = (state_q == RESP);
    assign resp_rdata_o       = rdata_q;
    assign resp_error_o       = error_q;
    assign mem_address_o      = mem_addr_q;
    assign mem_write_enable_o = mem_we_q;
    assign mem_write_data_o   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a 256-byte memory
//               model and a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_error_o;
    logic [31:0] mem_address_o;
    logic        mem_write_enable_o;
    logic [7:0]  mem_write_data_o;
    logic [7:0]  mem_data_i;

    load_store_unit #(.MEM_BYTES(256)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_write_i        (req_write_i),
        .req_size_i         (req_size_i),
        .req_unsigned_i     (req_unsigned_i),
        .req_addr_i         (req_addr_i),
        .req_wdata_i        (req_wdata_i),
        .resp_valid_o       (resp_valid_o),
        .resp_ready_i       (resp_ready_i),
        .resp_rdata_o       (resp_rdata_o),
        .resp_error_o       (resp_error_o),
        .mem_address_o      (mem_address_o),
        .mem_write_enable_o (mem_write_enable_o),
        .mem_write_data_o   (mem_write_data_o),
        .mem_data_i         (mem_data_i)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write committed at the clock edge.
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    assign mem_data_i = mem[mem_address_o[7:0]];
    always @(posedge clk) begin
        if (mem_write_enable_o) mem[mem_address_o[7:0]] = mem_write_data_o;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned acc;
        int unsigned lat;
    } exp_t;
    exp_t q[$];

    logic rdy_rand = 1'b0;
    logic rdy_hold = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-array semantics straight from the request rules.
    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err,
                                  output int unsigned n);
        longint v;
        int     base;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
           || (longint'(a) + longint'(n) - 1 >= 256);
        rd  = 32'd0;
        v   = 0;
        base = int'(a[7:0]);
        if (!err) begin
            if (w) begin
                for (int i = 0; i < int'(n); i++) ref_mem[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
            end else begin
                for (int i = 0; i < int'(n); i++) v = v + (longint'(ref_mem[base + i]) << (8 * i));
                if (!u && n < 4 && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
                rd = v[31:0];
            end
        end
    endfunction

    task automatic issue_raw(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int unsigned acc);
        int t = 0;
        while (!req_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got ready=0 expected ready=1");
        end
        req_write_i    = w;
        req_size_i     = sz;
        req_unsigned_i = u;
        req_addr_i     = a;
        req_wdata_i    = wd;
        req_valid_i    = 1'b1;
        @(posedge clk);
        #1;
        acc         = cyc;
        req_valid_i = 1'b0;
        req_wdata_i = $urandom;
        req_addr_i  = $urandom;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, output int unsigned acc);
        exp_t        e;
        logic [31:0] rd;
        logic        err;
        int unsigned n;
        model(w, sz, u, a, wd, rd, err, n);
        issue_raw(w, sz, u, a, wd, acc);
        e.rdata = rd;
        e.err   = err;
        e.acc   = acc;
        e.lat   = err ? 0 : n;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || !req_ready_o) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got pending=%0d expected 0", q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(req_ready_o), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata_o, 32'd0);
        check({tag, "_resp_error"}, 32'(resp_error_o), 32'd0);
        check({tag, "_mem_addr"},   mem_address_o, 32'd0);
        check({tag, "_mem_we"},     32'(mem_write_enable_o), 32'd0);
        check({tag, "_mem_wdata"},  32'(mem_write_data_o), 32'd0);
    endtask

    // Response-ready driver, updated just after each rising edge.
    initial begin
        resp_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            resp_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_hold;
        end
    end

    // Monitor: latency on first valid, then data/error on each handshake.
    logic pending_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            pending_valid = 1'b0;
        end else begin
            if (resp_valid_o && !pending_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got valid=1 expected no response");
                end else begin
                    check("resp_latency", cyc - q[0].acc, q[0].lat);
                end
            end
            if (resp_valid_o && resp_ready_i && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("resp_rdata", resp_rdata_o, e.rdata);
                check("resp_error", 32'(resp_error_o), 32'(e.err));
            end
            pending_valid = resp_valid_o && !resp_ready_i;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        int unsigned h;
        logic [31:0] a;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rst            = 1'b1;
        req_valid_i    = 1'b0;
        req_write_i    = 1'b0;
        req_size_i     = 2'd0;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'd0;
        req_wdata_i    = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Store word: byte sequence on the memory port, then memory contents.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, acc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("sw_addr",  mem_address_o, 32'h10 + 32'(k));
            check("sw_we",    32'(mem_write_enable_o), 32'd1);
            check("sw_wdata", 32'(mem_write_data_o), 32'((32'h11223344 >> (8 * k)) & 32'hFF));
        end
        wait_idle();
        check("sw_mem0", 32'(mem[16'h10]), 32'h44);
        check("sw_mem3", 32'(mem[16'h13]), 32'h11);

        // Load extension around 0x80 / 0x7F.
        issue(1'b1, 2'd0, 1'b0, 32'h20, 32'h00000080, acc);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000007F, acc);
        issue(1'b0, 2'd0, 1'b0, 32'h20, 32'd0, acc);
        issue(1'b0, 2'd0, 1'b1, 32'h20, 32'd0, acc);
        issue(1'b0, 2'd1, 1'b0, 32'h20, 32'd0, acc);
        wait_idle();

        // Faults.
        issue(1'b1, 2'd1, 1'b0, 32'h21, 32'hBEEF, acc);
        @(negedge clk);
        check("fault_no_we",    32'(mem_write_enable_o), 32'd0);
        check("fault_valid",    32'(resp_valid_o), 32'd1);
        wait_idle();
        check("fault_mem_kept", 32'(mem[16'h21]), 32'h7F);
        issue(1'b0, 2'd2, 1'b0, 32'hFE, 32'd0, acc);
        issue(1'b0, 2'd3, 1'b0, 32'h30, 32'd0, acc);
        issue(1'b0, 2'd2, 1'b0, 32'hFC, 32'd0, acc);
        issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'd0, acc);
        wait_idle();

        // Response backpressure.
        rdy_hold = 1'b0;
        @(posedge clk);
        #3;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, acc);
        h = 0;
        while (!resp_valid_o && h < 20) begin
            @(negedge clk);
            h++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(resp_valid_o), 32'd1);
            check("bp_rdata", resp_rdata_o, 32'h11223344);
            check("bp_ready", 32'(req_ready_o), 32'd0);
        end
        rdy_hold = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        h = cyc;
        @(negedge clk);
        check("bp_ready_after", 32'(req_ready_o), 32'd1);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, acc);
        check("bp_next_accept", acc, h + 1);
        wait_idle();

        // Reset in the middle of a word store.
        issue_raw(1'b1, 2'd2, 1'b0, 32'h40, 32'hAABBCCDD, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rs_byte2_addr", mem_address_o, 32'h42);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        ref_mem[16'h40] = 8'hDD;
        ref_mem[16'h41] = 8'hCC;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) check("rs_mem", 32'(mem[16'h40 + i]), 32'(ref_mem[16'h40 + i]));
        repeat (4) @(negedge clk);
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, acc);
        wait_idle();

        // Randomized traffic with random response backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 259));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom, acc);
        end
        rdy_rand = 1'b0;
        rdy_hold = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
